// File: rtl/matrix_frame_driver_if.sv
// rtl/matrix_frame_driver_if.sv - word-set handshake between the upstream buffer and the frame driver
interface matrix_frame_driver_if #(
   parameter int CHANNEL_NUMBER = 3,
   parameter int SPI_SIZE       = 8
);
   logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] data_in;
   logic                                    data_valid;
   logic                                    data_ready;

   modport master (output data_in, output data_valid, input data_ready);
   modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/matrix_frame_driver.sv
// rtl/matrix_frame_driver.sv - walks the column chain and serialises per-column words on parallel MOSI lines
module matrix_frame_driver #(
   parameter int CHANNEL_NUMBER   = 3,
   parameter int SPI_SIZE         = 8,
   parameter int MSB_FIRST        = 1,
   parameter int WORDS_PER_COLUMN = 3,
   parameter int COLUMN_COUNT     = 16,
   parameter int CLK_DIV          = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              frame_start,
   matrix_frame_driver_if.slave              s_data,
   output logic                              busy,
   output logic                              frame_done,
   output logic [$clog2(COLUMN_COUNT)-1:0]   column_index,
   output logic                              spi_clk,
   output logic [CHANNEL_NUMBER-1:0]         spi_mosi,
   output logic                              ser_clk,
   output logic                              ser_data,
   output logic                              ser_stcp,
   output logic                              ser_n_enable
);
   localparam int CNT_W  = $clog2(2 * CLK_DIV);
   localparam int BIT_W  = (SPI_SIZE > 1) ? $clog2(SPI_SIZE) : 1;
   localparam int WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
   localparam int COL_W  = $clog2(COLUMN_COUNT);

   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_END   = BIT_W'(SPI_SIZE - 1);
   localparam logic [WORD_W-1:0] WORD_END  = WORD_W'(WORDS_PER_COLUMN - 1);
   localparam logic [COL_W-1:0]  COL_END   = COL_W'(COLUMN_COUNT - 1);

   typedef enum logic [2:0] {IDLE, COL_SHIFT, COL_LATCH, LOAD, SHIFT, DONE} state_t;

   state_t                                  state_q, state_d;
   logic [CNT_W-1:0]                        cnt_q, cnt_d;
   logic [BIT_W-1:0]                        bit_q, bit_d;
   logic [WORD_W-1:0]                       word_q, word_d;
   logic [COL_W-1:0]                        col_q, col_d;
   logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] sreg_q, sreg_d, sreg_next;
   logic [CHANNEL_NUMBER-1:0]               mosi_q, mosi_d;
   logic spi_clk_q, spi_clk_d, ser_clk_q, ser_clk_d, ser_data_q, ser_data_d;
   logic ser_stcp_q, ser_stcp_d, ser_n_enable_q, ser_n_enable_d;
   logic data_ready_q, data_ready_d, busy_q, busy_d, frame_done_q, frame_done_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      word_d    = word_q;
      col_d     = col_q;
      sreg_d    = sreg_q;
      mosi_d    = mosi_q;
      sreg_next = sreg_q;
      for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
         sreg_next[ch] = (MSB_FIRST != 0) ? (sreg_q[ch] << 1) : (sreg_q[ch] >> 1);
      end

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = COL_SHIFT;
               cnt_d   = '0;
               word_d  = '0;
               col_d   = '0;
            end
         end
         COL_SHIFT: begin
            if (cnt_q == BIT_LAST) begin
               state_d = COL_LATCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         COL_LATCH: begin
            if (cnt_q == HALF_LAST) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOAD: begin
            // data_ready is high exactly while in LOAD, so valid alone completes the handshake
            if (s_data.data_valid) begin
               state_d = SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
               sreg_d  = s_data.data_in;
               for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
                  mosi_d[ch] = (MSB_FIRST != 0) ? s_data.data_in[ch][SPI_SIZE-1] : s_data.data_in[ch][0];
               end
            end
         end
         SHIFT: begin
            if (cnt_q != BIT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
               if (bit_q != BIT_END) begin
                  bit_d  = bit_q + BIT_W'(1);
                  sreg_d = sreg_next;
                  for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
                     mosi_d[ch] = (MSB_FIRST != 0) ? sreg_next[ch][SPI_SIZE-1] : sreg_next[ch][0];
                  end
               end else if (word_q != WORD_END) begin
                  word_d  = word_q + WORD_W'(1);
                  state_d = LOAD;
               end else begin
                  word_d = '0;
                  if (col_q != COL_END) begin
                     col_d   = col_q + COL_W'(1);
                     state_d = COL_SHIFT;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so every pin comes straight from a flop
      busy_d       = (state_d != IDLE);
      data_ready_d = (state_d == LOAD);
      frame_done_d = (state_d == DONE);
      spi_clk_d    = (state_d == SHIFT) && (cnt_d > HALF_LAST);
      ser_clk_d    = (state_d == COL_SHIFT) && (cnt_d > HALF_LAST);
      ser_data_d   = (state_d == COL_SHIFT) && (col_d == '0);
      ser_stcp_d   = (state_d == COL_LATCH);
      ser_n_enable_d = ser_n_enable_q;
      if (state_d == COL_SHIFT || state_d == COL_LATCH) begin
         ser_n_enable_d = 1'b1;
      end else if (state_d == LOAD) begin
         ser_n_enable_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         bit_q          <= '0;
         word_q         <= '0;
         col_q          <= '0;
         sreg_q         <= '0;
         mosi_q         <= '0;
         spi_clk_q      <= 1'b0;
         ser_clk_q      <= 1'b0;
         ser_data_q     <= 1'b0;
         ser_stcp_q     <= 1'b0;
         ser_n_enable_q <= 1'b1;
         data_ready_q   <= 1'b0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bit_q          <= bit_d;
         word_q         <= word_d;
         col_q          <= col_d;
         sreg_q         <= sreg_d;
         mosi_q         <= mosi_d;
         spi_clk_q      <= spi_clk_d;
         ser_clk_q      <= ser_clk_d;
         ser_data_q     <= ser_data_d;
         ser_stcp_q     <= ser_stcp_d;
         ser_n_enable_q <= ser_n_enable_d;
         data_ready_q   <= data_ready_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign s_data.data_ready = data_ready_q;
   assign busy              = busy_q;
   assign frame_done        = frame_done_q;
   assign column_index      = col_q;
   assign spi_clk           = spi_clk_q;
   assign spi_mosi          = mosi_q;
   assign ser_clk           = ser_clk_q;
   assign ser_data          = ser_data_q;
   assign ser_stcp          = ser_stcp_q;
   assign ser_n_enable      = ser_n_enable_q;
endmodule

// File: doc/matrix_frame_driver.md
# matrix_frame_driver

Frame-level output driver for the LED matrix FPGA: it walks the column-select shift-register chain through every column of a frame. For each column it pulls a parametrised number of words per channel from the upstream buffer over a valid/ready handshake. Each word is serialised on CHANNEL_NUMBER parallel SPI MOSI lines with a configurable clock divider. It replaces per-column manual sequencing by the controller: one `frame_start` pulse produces a complete frame and a `frame_done` pulse.

## Interface
- CHANNEL_NUMBER, 3, number of parallel MOSI lines sharing one spi_clk
- SPI_SIZE, 8, bits per word per channel
- MSB_FIRST, 1, 1 = bit SPI_SIZE-1 sent first, 0 = bit 0 first
- WORDS_PER_COLUMN, 3, words transferred per channel per column (≥1)
- COLUMN_COUNT, 16, columns per frame (≥2)
- CLK_DIV, 2, half-period of spi_clk/ser_clk in clk cycles (≥1)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  pulse; starts a frame at column 0 when idle
- data_in  in  [SPI_SIZE-1:0] x CHANNEL_NUMBER  one word per channel
- data_valid  in  1  data_in holds a valid word set
- data_ready  out  1  block accepts data_in this cycle
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last bit of the last column
- column_index  out  $clog2(COLUMN_COUNT)  column currently being driven
- spi_clk  out  1  SPI mode 0 clock, idle low
- spi_mosi  out  CHANNEL_NUMBER  per-channel serial data
- ser_clk, ser_data, ser_stcp  out  1 each  column shift-register clock, data, latch
- ser_n_enable  out  1  column output enable, active low

## Operation
- States: IDLE, COL_SHIFT, COL_LATCH, LOAD, SHIFT, DONE.
- IDLE: `busy` = 0. `frame_start` → COL_SHIFT, `column_index` = 0.
- COL_SHIFT: `ser_n_enable` = 1 (blanking). `ser_data` = 1 for column 0 and 0 otherwise, held for 2·CLK_DIV cycles. `ser_clk` is low for CLK_DIV cycles, then high for CLK_DIV cycles. → COL_LATCH.
- COL_LATCH: `ser_stcp` high for CLK_DIV cycles → LOAD. `ser_n_enable` returns to 0 on the first LOAD cycle.
- LOAD: `data_ready` = 1 (state-decoded level).
  - On `data_valid` && `data_ready`, all channels of `data_in` are captured into shift registers and the state moves to SHIFT.
  - With no valid word, the block waits indefinitely with `spi_clk` low.
- SHIFT: sends SPI_SIZE bits. Each bit is CLK_DIV cycles with `spi_clk` low (MOSI set at the start of the low phase), then CLK_DIV cycles high.
  - Bit order follows MSB_FIRST.
  - A word counter counts 0..WORDS_PER_COLUMN-1.
- End of word:
  - More words remain → LOAD.
  - Last word and `column_index` < COLUMN_COUNT-1 → increment `column_index`, → COL_SHIFT.
  - Last word of the last column → DONE.
- DONE: `frame_done` = 1 for one cycle → IDLE. The last column stays enabled (`ser_n_enable` = 0) until the next frame or reset.
- `frame_start` while `busy`: ignored, with no effect on counters.
- `data_valid` outside LOAD: ignored; `data_ready` stays 0.
- Reset mid-operation: all outputs take their reset values asynchronously and the state returns to IDLE. The partial frame is discarded.

## Timing
- Reset values:
  - `spi_clk`, `spi_mosi`, `ser_clk`, `ser_data`, `ser_stcp` = 0.
  - `ser_n_enable` = 1.
  - `data_ready`, `busy`, `frame_done` = 0.
  - `column_index` = 0.
- All outputs are registered, with no combinational path from input to output.
- `frame_start` sampled in cycle N → `busy` = 1 and `ser_n_enable` = 1 in cycle N+1.
- Column overhead is 3·CLK_DIV cycles (COL_SHIFT + COL_LATCH). LOAD is at least 1 cycle. One word takes 2·CLK_DIV·SPI_SIZE cycles.
- Zero-stall frame length: COLUMN_COUNT·(3·CLK_DIV + WORDS_PER_COLUMN·(1 + 2·CLK_DIV·SPI_SIZE)) + 1 cycles, counted from the first busy cycle to the `frame_done` cycle inclusive.
- `spi_clk` idles low between words; the MOSI line holds its last bit.

## Test plan
- **Bit order, MSB_FIRST:** CHANNEL_NUMBER=2, CLK_DIV=1, ch0=0xA5, ch1=0x3C → ch0 rising-edge samples 1,0,1,0,0,1,0,1 and ch1 samples 0,0,1,1,1,1,0,0.
- **Bit order, LSB_FIRST:** MSB_FIRST=0, same data → ch0 samples 1,0,1,0,0,1,0,1 and ch1 samples 0,0,1,1,1,1,0,0, each taken from bit 0 upward; checked against a reversed reference.
- **Full frame:** COLUMN_COUNT=4, WORDS_PER_COLUMN=2, CLK_DIV=1, `data_valid` held high.
  - `ser_data` at the `ser_clk` rising edges: 1,0,0,0.
  - Exactly 4 `ser_stcp` pulses, 8 words accepted, `column_index` 0→3.
  - A single `frame_done` at cycle 4·(3+2·17)+1 = 149.
- **Backpressure:** `data_valid` withheld for 5 cycles in LOAD → `data_ready` stays 1, `spi_clk` stays 0, no bit emitted. The word is accepted on the first valid cycle.
- **Ignored start:** second `frame_start` mid-frame → frame length and `frame_done` count unchanged (exactly 1).
- **Reset mid-word:** `rst_n` low during SHIFT bit 3 → all outputs at reset values in the same cycle. After release, a new `frame_start` completes a normal frame beginning at column 0.
